// File: rtl/lab8_soc_pio_pkg.sv
// Shared constants and types for the lab8_soc input PIO with edge capture.
package lab8_soc_pio_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 2;

    localparam logic [ADDR_W-1:0] ADDR_DATA    = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_RSVD    = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGECAP = 2'd3;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

    // Slave write transaction as seen by the register file.
    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] data;
    } pio_wr_t;

    // Pick the edge set that should be captured; unknown encodings fall back to rising.
    function automatic logic [DATA_W-1:0] edge_select(
        input logic [DATA_W-1:0] rise,
        input logic [DATA_W-1:0] fall,
        input int unsigned       edge_type
    );
        logic [DATA_W-1:0] sel;
        sel = rise;
        case (edge_type)
            EDGE_FALL: sel = fall;
            EDGE_ANY:  sel = rise | fall;
            default:   sel = rise;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/lab8_soc_sync_edge.sv
// Input synchroniser, previous-sample register and settle-gated edge detector
// for one asynchronous input bus.
module lab8_soc_sync_edge
    import lab8_soc_pio_pkg::*;
#(
    parameter int unsigned      WIDTH       = 1,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter int unsigned      EDGE_TYPE   = EDGE_RISE,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] edge_c
);

    localparam int unsigned SETTLE_MAX = SYNC_STAGES + 1;
    localparam int unsigned CNT_W      = $clog2(SETTLE_MAX + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  prev_q;
    logic [CNT_W-1:0]                  settle_q;
    logic                              settled_c;
    logic [WIDTH-1:0]                  rise_c;
    logic [WIDTH-1:0]                  fall_c;

    // Shift chain: stage 0 samples the pad, the last stage is the clean value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= RESET_VALUE;
        end else begin
            prev_q <= sync_out;
        end
    end

    // Hold off detection until the chain and prev hold real samples of the pad.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            settle_q <= '0;
        end else if (settle_q != CNT_W'(SETTLE_MAX)) begin
            settle_q <= settle_q + CNT_W'(1);
        end
    end

    assign settled_c = (settle_q == CNT_W'(SETTLE_MAX));
    assign rise_c    = sync_out & ~prev_q;
    assign fall_c    = ~sync_out & prev_q;

    assign edge_c = settled_c
                  ? WIDTH'(edge_select(DATA_W'(rise_c), DATA_W'(fall_c), EDGE_TYPE))
                  : '0;

endmodule

// File: rtl/lab8_soc_pio_in_edge.sv
// Avalon-MM input PIO: synchronised data read, sticky edge capture with
// write-1-to-clear, and a maskable level interrupt.
module lab8_soc_pio_in_edge
    import lab8_soc_pio_pkg::*;
#(
    parameter int unsigned      WIDTH       = 1,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter int unsigned      EDGE_TYPE   = EDGE_RISE,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [WIDTH-1:0]  in_port,
    output logic              irq
);

    pio_wr_t          wr_c;
    logic             wr_en_c;
    logic [WIDTH-1:0] wdata_c;
    logic [WIDTH-1:0] clr_c;
    logic             unused_wdata;

    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] edge_c;
    logic [WIDTH-1:0] irq_mask_q;
    logic [WIDTH-1:0] edge_capture_q;

    assign wr_c.address = address;
    assign wr_c.data    = writedata;
    assign wr_en_c      = chipselect & ~write_n;
    assign wdata_c      = wr_c.data[WIDTH-1:0];
    assign unused_wdata = ^wr_c.data;

    assign clr_c = (wr_en_c && (wr_c.address == ADDR_EDGECAP)) ? wdata_c : '0;

    lab8_soc_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE),
        .RESET_VALUE (RESET_VALUE)
    ) u_sync_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_port  (in_port),
        .sync_out (sync_out),
        .edge_c   (edge_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask_q <= '0;
        end else if (wr_en_c && (wr_c.address == ADDR_IRQMASK)) begin
            irq_mask_q <= wdata_c;
        end
    end

    // A new edge in the same cycle as a clear of that bit keeps the bit set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture_q <= '0;
        end else begin
            edge_capture_q <= (edge_capture_q & ~clr_c) | edge_c;
        end
    end

    assign irq = |(edge_capture_q & irq_mask_q);

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata = DATA_W'(sync_out);
            ADDR_RSVD:    readdata = '0;
            ADDR_IRQMASK: readdata = DATA_W'(irq_mask_q);
            ADDR_EDGECAP: readdata = DATA_W'(edge_capture_q);
            default:      readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_lab8_soc_pio_in_edge.sv
// Scoreboard bench for the input PIO: a 1-bit rising-edge instance and an
// 8-bit any-edge instance driven with directed vectors.
module tb_lab8_soc_pio_in_edge;
    import lab8_soc_pio_pkg::*;

    typedef struct {
        string       name;
        int          dut;
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        chk_req = 1'b0;

    logic [1:0]  addr1, addr8;
    logic        cs1, cs8, wn1, wn8;
    logic [31:0] wd1, wd8;
    logic [31:0] rd1, rd8;
    logic [0:0]  in1;
    logic [7:0]  in8;
    logic        irq1, irq8;

    always #10 clk = ~clk;

    lab8_soc_pio_in_edge u_dut1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (addr1),
        .chipselect (cs1),
        .write_n    (wn1),
        .writedata  (wd1),
        .readdata   (rd1),
        .in_port    (in1),
        .irq        (irq1)
    );

    lab8_soc_pio_in_edge #(
        .WIDTH       (8),
        .SYNC_STAGES (2),
        .EDGE_TYPE   (EDGE_ANY),
        .RESET_VALUE (8'h00)
    ) u_dut8 (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (addr8),
        .chipselect (cs8),
        .write_n    (wn8),
        .writedata  (wd8),
        .readdata   (rd8),
        .in_port    (in8),
        .irq        (irq8)
    );

    // Monitor: pops one expectation per presented read and compares it.
    exp_t        mon_e;
    logic [31:0] mon_rd;
    logic        mon_irq;
    initial begin
        forever begin
            @(posedge chk_req);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty: read presented with no expectation queued");
            end else begin
                mon_e   = exp_q.pop_front();
                mon_rd  = (mon_e.dut == 1) ? rd1 : rd8;
                mon_irq = (mon_e.dut == 1) ? irq1 : irq8;
                n_checks++;
                if (mon_rd !== mon_e.rd) begin
                    n_fail++;
                    $display("FAIL %s readdata: got 0x%08h expected 0x%08h", mon_e.name, mon_rd, mon_e.rd);
                end
                n_checks++;
                if (mon_irq !== mon_e.irq) begin
                    n_fail++;
                    $display("FAIL %s irq: got %b expected %b", mon_e.name, mon_irq, mon_e.irq);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input int dut, input logic [1:0] a, input logic [31:0] rd,
                         input logic ir, input string name);
        exp_t e;
        if (dut == 1) addr1 = a;
        else          addr8 = a;
        e.name = name;
        e.dut  = dut;
        e.rd   = rd;
        e.irq  = ir;
        exp_q.push_back(e);
        #1 chk_req = 1'b1;
        #1 chk_req = 1'b0;
        #1;
    endtask

    task automatic write(input int dut, input logic [1:0] a, input logic [31:0] d);
        if (dut == 1) begin
            addr1 = a; wd1 = d; cs1 = 1'b1; wn1 = 1'b0;
        end else begin
            addr8 = a; wd8 = d; cs8 = 1'b1; wn8 = 1'b0;
        end
        @(posedge clk);
        #1;
        cs1 = 1'b0; wn1 = 1'b1;
        cs8 = 1'b0; wn8 = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        addr1 = '0; addr8 = '0;
        cs1 = 1'b0; cs8 = 1'b0; wn1 = 1'b1; wn8 = 1'b1;
        wd1 = '0; wd8 = '0;
        in1 = 1'b1; in8 = 8'h00;

        // Reset state, then settle gate with the pad already high
        tick(2);
        check(1, ADDR_EDGECAP, 32'h0, 1'b0, "rst_edgecap1");
        check(1, ADDR_IRQMASK, 32'h0, 1'b0, "rst_irqmask1");
        check(8, ADDR_EDGECAP, 32'h0, 1'b0, "rst_edgecap8");
        reset_n = 1'b1;
        tick(1);
        check(1, ADDR_DATA, 32'h0, 1'b0, "t1_data_edge1");
        tick(1);
        check(1, ADDR_DATA, 32'h1, 1'b0, "t1_data_edge2");
        for (int i = 0; i < 20; i++) begin
            check(1, ADDR_EDGECAP, 32'h0, 1'b0, "t1_no_spurious_capture");
            tick(1);
        end

        // Rising edge latency on the default instance
        in1 = 1'b0;
        tick(4);
        write(1, ADDR_IRQMASK, 32'h1);
        check(1, ADDR_IRQMASK, 32'h1, 1'b0, "t2_mask");
        in1 = 1'b1;
        tick(1);
        check(1, ADDR_DATA, 32'h0, 1'b0, "t2_data_edge1");
        tick(1);
        check(1, ADDR_DATA, 32'h1, 1'b0, "t2_data_edge2");
        check(1, ADDR_EDGECAP, 32'h0, 1'b0, "t2_cap_edge2");
        tick(1);
        check(1, ADDR_EDGECAP, 32'h1, 1'b1, "t2_cap_edge3");

        // Write-1-to-clear, falling edge ignored, write-0 and ignored addresses
        write(1, ADDR_EDGECAP, 32'h1);
        check(1, ADDR_EDGECAP, 32'h0, 1'b0, "t3_w1c");
        in1 = 1'b0;
        tick(4);
        check(1, ADDR_EDGECAP, 32'h0, 1'b0, "t3_fall_ignored");
        in1 = 1'b1;
        tick(3);
        check(1, ADDR_EDGECAP, 32'h1, 1'b1, "t3_recapture");
        write(1, ADDR_EDGECAP, 32'h0);
        check(1, ADDR_EDGECAP, 32'h1, 1'b1, "t3_w0_nochange");
        write(1, ADDR_DATA, 32'hFFFF_FFFF);
        write(1, ADDR_RSVD, 32'h0000_0000);
        check(1, ADDR_IRQMASK, 32'h1, 1'b1, "t3_ignored_writes");
        check(1, ADDR_RSVD, 32'h0, 1'b1, "t3_rsvd_read");

        // Clear and new edge in the same cycle: set wins
        in1 = 1'b0;
        tick(4);
        in1 = 1'b1;
        tick(2);
        write(1, ADDR_EDGECAP, 32'h1);
        check(1, ADDR_EDGECAP, 32'h1, 1'b1, "t4_set_wins");
        write(1, ADDR_EDGECAP, 32'h1);
        check(1, ADDR_EDGECAP, 32'h0, 1'b0, "t4_clear");

        // 8-bit any-edge instance with masking
        write(8, ADDR_IRQMASK, 32'h0F);
        in8 = 8'h81;
        tick(3);
        check(8, ADDR_EDGECAP, 32'h81, 1'b1, "t5_cap81");
        check(8, ADDR_DATA, 32'h81, 1'b1, "t5_data81");
        write(8, ADDR_EDGECAP, 32'h01);
        check(8, ADDR_EDGECAP, 32'h80, 1'b0, "t5_clr_bit0");
        write(8, ADDR_IRQMASK, 32'hF0);
        check(8, ADDR_IRQMASK, 32'hF0, 1'b1, "t5_mask_f0");
        write(8, ADDR_EDGECAP, 32'h80);
        check(8, ADDR_EDGECAP, 32'h0, 1'b0, "t5_clr_bit7");
        in8 = 8'h00;
        tick(3);
        check(8, ADDR_EDGECAP, 32'h81, 1'b1, "t5_fall_any");
        write(8, ADDR_EDGECAP, 32'hFF);
        check(8, ADDR_EDGECAP, 32'h0, 1'b0, "t5_clr_all");

        // Asynchronous reset mid-operation
        write(8, ADDR_IRQMASK, 32'hFF);
        in8 = 8'hFF;
        tick(3);
        check(8, ADDR_EDGECAP, 32'hFF, 1'b1, "t6_capff");
        tick(1);
        reset_n = 1'b0;
        #2;
        check(8, ADDR_EDGECAP, 32'h0, 1'b0, "t6_rst_cap");
        check(8, ADDR_IRQMASK, 32'h0, 1'b0, "t6_rst_mask");
        check(8, ADDR_DATA, 32'h0, 1'b0, "t6_rst_sync");
        check(1, ADDR_EDGECAP, 32'h0, 1'b0, "t6_rst_cap1");

        #5;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lab8_soc_pio_in_edge.md
Name: lab8_soc_pio_in_edge

Overview:
Avalon-MM slave input PIO. It is the read-direction counterpart of the SoC's single-register output PIOs (for example, the USB HPI control strobes).
- Synchronises an external input bus into the clk domain.
- Detects edges on each bit and latches them in a sticky edge-capture register.
- Raises a maskable level interrupt to the Nios II.
- Sits on the lab8_soc system interconnect with a 2-bit word address and zero-wait-state reads.

Parameters:
WIDTH, 1, number of input bits (1..32)
SYNC_STAGES, 2, synchroniser flop depth (2..4)
EDGE_TYPE, 0, 0 = rising, 1 = falling, 2 = any edge
RESET_VALUE, 0, reset value of the synchroniser flops and the previous-sample register

Ports:
clk  in  1  system clock; the single clock of the block
reset_n  in  1  asynchronous, active-low reset
address  in  2  word address: 0 data, 1 reserved, 2 irqmask, 3 edgecapture
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  combinational read data, zero wait states
in_port  in  WIDTH  asynchronous external inputs
irq  out  1  level interrupt, active high

Behaviour:
- Reset: asynchronous on reset_n low. Values while reset is asserted:
  - sync chain and prev = RESET_VALUE
  - irq_mask = 0, edge_capture = 0
  - settle counter = 0
  - irq = 0
  - readdata = 0 when address selects irq_mask or edge_capture
- Synchroniser:
  - sync[0] <= in_port; sync[i] <= sync[i-1].
  - sync_out = sync[SYNC_STAGES-1].
  - Input latency: a change sampled at clock edge 1 appears in sync_out after edge SYNC_STAGES.
- Edge detection:
  - prev <= sync_out on every clock.
  - rise = sync_out & ~prev; fall = ~sync_out & prev; edge selected by EDGE_TYPE.
- Settle gate: a counter runs from 0 to SYNC_STAGES+1 after reset release, then saturates. Edge detection is masked until the counter saturates, so no spurious capture occurs when in_port differs from RESET_VALUE.
- edge_capture[WIDTH-1:0] is sticky:
  - A bit sets on the clock after its edge is detected.
  - Writing address 3 with chipselect and !write_n clears each bit where writedata is 1 (write-1-to-clear).
  - A set and a clear of the same bit in the same cycle: set wins, the bit stays 1.
  - Bits written 0 are unaffected.
- irq_mask[WIDTH-1:0]: written at address 2 on chipselect & !write_n, taking writedata[WIDTH-1:0].
- Writes to addresses 0 and 1 are ignored.
- irq = |(edge_capture & irq_mask), registered-path only: irq asserts in the same cycle edge_capture or irq_mask updates, with no extra flop.
- readdata (combinational, upper bits zero-extended):
  - address 0: sync_out
  - address 1: 0
  - address 2: irq_mask
  - address 3: edge_capture
- readdata does not depend on chipselect; reads have no side effects.
- Total latency, in_port toggle to edge_capture/irq: SYNC_STAGES+1 clock edges (3 for the defaults).
- A pulse shorter than one clock period may be missed; this is acceptable and documented.
- A reset mid-operation clears all state immediately. The settle gate restarts after reset release.

Decomposition:
- Package lab8_soc_pio_pkg holds:
  - address constants ADDR_DATA = 0, ADDR_IRQMASK = 2, ADDR_EDGECAP = 3
  - EDGE_RISE, EDGE_FALL and EDGE_ANY encodings
- One natural sub-module: lab8_soc_sync_edge. It holds the per-bus synchroniser, prev register, settle counter and edge output, parameterised by WIDTH, SYNC_STAGES, EDGE_TYPE and RESET_VALUE.
- The top level holds the register file, write decode, read mux and irq.

Test Plan:
1. Reset with in_port = 1 (WIDTH = 1, RESET_VALUE = 0) -> after reset release edge_capture stays 0 and irq stays 0 for 20 cycles; the address 0 read returns 1 after edge 2.
2. Defaults, irq_mask = 1, in_port 0->1 sampled at edge 1 -> address 0 reads 1 after edge 2; edge_capture = 1 and irq = 1 after edge 3.
3. Write 0x1 to address 3 -> edge_capture = 0 and irq = 0 on the next cycle. Then write 0x0 -> no change.
4. Write-1-to-clear in the same cycle a new rising edge is captured -> edge_capture stays 1 and irq stays 1.
5. WIDTH = 8, EDGE_TYPE = 2, irq_mask = 0x0F, toggle bits 7 and 0 -> edge_capture = 0x81 and irq = 1. With irq_mask = 0xF0 and only bit 7 captured -> irq = 1; clear bit 7 -> irq = 0.
6. Assert reset_n low mid-capture with edge_capture = 0xFF -> edge_capture, irq_mask and irq go to 0 immediately, without waiting for a clock edge.
